// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM states and the
// legal oversampling ratios.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [5:0] PRESC_8  = 6'd8;
   localparam logic [5:0] PRESC_16 = 6'd16;
   localparam logic [5:0] PRESC_32 = 6'd32;

   // Anything other than 16 or 32 falls back to 8 clocks per bit.
   function automatic logic [5:0] legal_prescale(input logic [5:0] p);
      return (p == PRESC_16 || p == PRESC_32) ? p : PRESC_8;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the UART receiver: counts clocks within a bit cell and
// majority-votes three mid-cell samples of the synchronised line.
module uart_rx_sampler
   import uart_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       active,
   input  logic [5:0] p,
   input  logic       rx_s,
   output logic       bit_done,
   output logic       sampled_bit
);

   logic [5:0] edge_cnt;
   logic [5:0] half;
   logic [2:0] samp;

   assign half        = {1'b0, p[5:1]};
   assign bit_done    = active && (edge_cnt == p - 6'd1);
   assign sampled_bit = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

   // edge_cnt sits at 0 while idle so the first START cycle is count 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_cnt <= '0;
         samp     <= '0;
      end else if (!active) begin
         edge_cnt <= '0;
      end else begin
         edge_cnt <= bit_done ? 6'd0 : edge_cnt + 6'd1;
         if (edge_cnt == half - 6'd1) samp[0] <= rx_s;
         if (edge_cnt == half)        samp[1] <= rx_s;
         if (edge_cnt == half + 6'd1) samp[2] <= rx_s;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises RX_IN, walks start/data/parity/stop with the
// sampler's voted bits, and emits one-cycle data_valid / error strobes.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   logic                  sync1, rx_s;
   state_t                state;
   logic [5:0]            p;
   logic                  par_en_l, par_typ_l, par_bad;
   logic [DATA_WIDTH-1:0] shreg;
   logic [BW-1:0]         bit_cnt;
   logic                  bit_done, sampled_bit;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= RX_IN;
         rx_s  <= sync1;
      end
   end

   uart_rx_sampler u_sampler (
      .clk        (CLK),
      .rst        (RST),
      .active     (state != IDLE),
      .p          (p),
      .rx_s       (rx_s),
      .bit_done   (bit_done),
      .sampled_bit(sampled_bit)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         p          <= PRESC_8;
         par_en_l   <= 1'b0;
         par_typ_l  <= 1'b0;
         par_bad    <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         P_DATA     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         case (state)
            // Frame configuration is frozen here; later pin changes are ignored.
            IDLE: if (!rx_s) begin
               state     <= START;
               p         <= legal_prescale(prescale);
               par_en_l  <= PAR_EN;
               par_typ_l <= PAR_TYP;
               par_bad   <= 1'b0;
            end
            START: if (bit_done) begin
               if (sampled_bit) state <= IDLE;
               else begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: if (bit_done) begin
               shreg[bit_cnt] <= sampled_bit;
               if (bit_cnt == LAST_BIT) state <= par_en_l ? PARITY : STOP;
               else                     bit_cnt <= bit_cnt + 1'b1;
            end
            PARITY: if (bit_done) begin
               par_bad <= sampled_bit != (^shreg ^ par_typ_l);
               state   <= STOP;
            end
            STOP: if (bit_done) begin
               state   <= IDLE;
               stp_err <= !sampled_bit;
               par_err <= par_bad;
               if (sampled_bit && !par_bad) begin
                  P_DATA     <= shreg;
                  data_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx: frames are built from bit lists
// and the expected strobe, data and latency are derived from the frame rules.
module tb_uart_rx;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic [5:0] prescale;
   logic       PAR_EN, PAR_TYP;
   logic [7:0] P_DATA;
   logic       data_valid, par_err, stp_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [7:0] data;
      logic       dv, pe, se;
      int         t;
   } ev_t;

   ev_t        got_q[$];
   ev_t        exp_q[$];
   logic [7:0] last_good;
   logic       dv_p = 1'b0, pe_p = 1'b0, se_p = 1'b0;

   uart_rx #(.DATA_WIDTH(8)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .RX_IN     (RX_IN),
      .prescale  (prescale),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
      .P_DATA    (P_DATA),
      .data_valid(data_valid),
      .par_err   (par_err),
      .stp_err   (stp_err)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Record every strobe cycle; a strobe must never be high two cycles running.
   always @(negedge CLK) begin
      if (data_valid || par_err || stp_err) begin
         chk("strobe_width", {29'b0, dv_p & data_valid, pe_p & par_err, se_p & stp_err}, 32'd0);
         got_q.push_back('{P_DATA, data_valid, par_err, stp_err, cyc});
      end
      dv_p = data_valid;
      pe_p = par_err;
      se_p = stp_err;
   end

   function automatic int eff_p(input logic [5:0] ps);
      return (ps == 6'd16) ? 16 : (ps == 6'd32) ? 32 : 8;
   endfunction

   // Drive one frame starting at the current negedge. Expected latency: two
   // synchroniser edges, one edge to leave IDLE, the frame, then the strobe.
   task automatic send_frame(input logic [7:0] d, input logic [5:0] ps, input logic pen,
                             input logic ptyp, input logic bad_par, input logic bad_stop,
                             input int glitch_bit, input bit timed);
      int   p;
      logic bq[$];
      ev_t  e;
      p = eff_p(ps);
      bq.push_back(1'b0);
      for (int i = 0; i < 8; i++) bq.push_back(d[i]);
      if (pen) bq.push_back(^d ^ ptyp ^ bad_par);
      bq.push_back(!bad_stop);
      e.se = bad_stop;
      e.pe = pen & bad_par;
      e.dv = !e.se && !e.pe;
      if (e.dv) last_good = d;
      e.data = last_good;
      e.t    = timed ? cyc + 3 + bq.size() * p : -1;
      exp_q.push_back(e);
      prescale = ps;
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      for (int i = 0; i < bq.size(); i++) begin
         for (int c = 0; c < p; c++) begin
            RX_IN = (glitch_bit + 1 == i && c == p / 2) ? ~bq[i] : bq[i];
            @(negedge CLK);
         end
         if (i == 0) begin
            prescale = 6'($urandom);
            PAR_EN   = 1'($urandom);
            PAR_TYP  = 1'($urandom);
         end
      end
      RX_IN = 1'b1;
   endtask

   task automatic idle(input int n);
      RX_IN = 1'b1;
      repeat (n) @(negedge CLK);
   endtask

   task automatic drain(input string tag);
      ev_t g, e;
      idle(8);
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_pdata"}, g.data, e.data);
         chk({tag, "_dv"}, g.dv, e.dv);
         chk({tag, "_par_err"}, g.pe, e.pe);
         chk({tag, "_stp_err"}, g.se, e.se);
         if (e.t >= 0) chk({tag, "_latency"}, g.t, e.t);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      logic [5:0] ps_tab[6];
      logic [7:0] d;
      ps_tab    = '{6'd8, 6'd16, 6'd32, 6'd10, 6'd0, 6'd63};
      last_good = 8'h00;
      RST       = 1'b1;
      RX_IN     = 1'b1;
      prescale  = 6'd8;
      PAR_EN    = 1'b0;
      PAR_TYP   = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_pdata", P_DATA, 32'd0);
      chk("rst_dv", data_valid, 32'd0);
      chk("rst_par_err", par_err, 32'd0);
      chk("rst_stp_err", stp_err, 32'd0);
      RST = 1'b0;
      idle(5);

      // Good 0xA5 with even parity, then the same frame with a flipped parity bit.
      send_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b1);
      idle(4);
      send_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b1);
      drain("par");

      send_frame(8'h3C, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1);
      drain("stop");

      // Short low pulse must be rejected as a glitch.
      prescale = 6'd8;
      RX_IN    = 1'b0;
      repeat (3) @(negedge CLK);
      idle(40);
      drain("glitch");

      // Back-to-back odd-parity frames; second has a one-cycle glitch in bit 3.
      send_frame(8'h00, 6'd32, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b1);
      send_frame(8'hFF, 6'd32, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b0);
      drain("b2b");

      // Reset in the middle of data bit 4, then a clean 0x5A.
      prescale = 6'd16;
      PAR_EN   = 1'b0;
      RX_IN    = 1'b0;
      repeat (16) @(negedge CLK);
      d = 8'hC3;
      for (int i = 0; i < 5; i++) begin
         RX_IN = d[i];
         repeat (i == 4 ? 8 : 16) @(negedge CLK);
      end
      RST = 1'b1;
      RX_IN = 1'b1;
      @(negedge CLK);
      chk("midrst_pdata", P_DATA, 32'd0);
      chk("midrst_dv", data_valid, 32'd0);
      last_good = 8'h00;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      idle(5);
      send_frame(8'h5A, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b1);
      drain("after_rst");

      for (int n = 0; n < 40; n++) begin
         send_frame(8'($urandom), ps_tab[$urandom_range(0, 5)], 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1, 1'b1);
         drain("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
